input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Sits between the board pins (push-buttons, DIP switches) and the memory-mapped external-device block; its outputs drive that block's switch and button inputs.
- Synchronises and debounces all 5 buttons and 24 switches into clean levels.
- Adds per-button press pulses and sticky press-event flags, so software polling the button address cannot miss short presses.

Parameters:
- NUM_BTN, 5, number of push-buttons.
- NUM_SW, 24, number of switches.
- DEBOUNCE_CYCLES, 500000, clk_i cycles per sample tick (20 ms at 25 MHz); legal range >= 1.
- CNT_W, 20, tick counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk_i, input, 1, system clock; the only clock.
- rst_n_i, input, 1, asynchronous active-low reset.
- btn_raw_i, input, NUM_BTN, raw button pins, asynchronous to clk_i.
- sw_raw_i, input, NUM_SW, raw switch pins, asynchronous to clk_i.
- evt_clr_i, input, NUM_BTN, write-1-to-clear strobe for btn_evt_o, one bit per button.
- btn_lvl_o, output, NUM_BTN, debounced button level.
- sw_lvl_o, output, NUM_SW, debounced switch level.
- btn_press_o, output, NUM_BTN, one-cycle pulse on a debounced 0->1 transition.
- btn_evt_o, output, NUM_BTN, sticky press flag.
- tick_o, output, 1, sample-tick strobe, exported for debug.

Behaviour:
- Reset (rst_n_i low, asynchronous): all synchroniser, history, level, pulse and event flops go to 0; tick counter goes to 0; every output reads 0. Release is synchronous to clk_i. Asserting reset mid-debounce discards all history.
- Synchroniser: each raw bit passes through 2 flops (s1, s2). Only s2 is used downstream.
- Tick counter: counts 0..DEBOUNCE_CYCLES-1 then wraps to 0. tick is combinational, high while the count equals DEBOUNCE_CYCLES-1. With DEBOUNCE_CYCLES=1, tick is high every cycle. tick_o equals tick.
- Per-bit debounce (buttons and switches use identical logic): two history flops h1, h0.
  - On a tick edge: h1 <= s2 and h0 <= h1.
  - On the same edge, lvl <= s2 if s2 == h1 == h0, using pre-edge values; otherwise lvl holds.
  - Effect: lvl changes only at the third consecutive tick edge at which s2 holds the new value.
  - Any glitch seen at a tick restarts qualification.
  - Glitches between ticks are ignored.
- Latency for a clean step on a raw pin: minimum 2 + 2*DEBOUNCE_CYCLES + 1 cycles, maximum 2 + 3*DEBOUNCE_CYCLES cycles, to the lvl change.
- btn_press_o[i]: registered at the same edge as the level update. It is 1 exactly when button lvl goes 0->1, so it is high during the first cycle btn_lvl_o[i] reads 1, then drops the next cycle. It never asserts on a 1->0 transition.
- btn_evt_o[i]: next = (evt & ~evt_clr_i[i]) | set, where set is the same term that raises btn_press_o[i]. Updates on every edge.
  - Set and clear in the same cycle: set wins, and the flag stays 1.
  - Clear with no flag set has no effect.
  - Multiple presses before a clear leave a single flag; there is no count.
- Switches produce no pulses or events.
- No combinational path from any input to any output.

Optional Feature:
- Macro: INPUT_COND_RELEASE_EVT_EN.
- Defined:
  - Adds output btn_rel_o (NUM_BTN): a one-cycle pulse on a debounced 1->0 transition, same timing as btn_press_o.
  - Adds output btn_rel_evt_o (NUM_BTN): sticky release flag, cleared by the same evt_clr_i bits; set wins.
  - Reset value of both is 0.
- Undefined: neither port exists and no release logic is built. Press behaviour is identical in both builds.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset: hold rst_n_i low with btn_raw_i=5'h1F and sw_raw_i=24'hFFFFFF -> all outputs stay 0. Release reset and hold inputs -> btn_lvl_o=5'h1F and sw_lvl_o=24'hFFFFFF within 14 cycles; btn_press_o pulses 5'h1F for exactly 1 cycle; btn_evt_o=5'h1F.
- Clean press: btn_raw_i[2] rises and stays -> btn_lvl_o[2] rises after 11..14 cycles; btn_press_o[2] is high 1 cycle; btn_evt_o[2]=1 and stays 1 after release.
- Bounce: toggle btn_raw_i[0] so it is sampled 1,0,1,1,1 at successive ticks -> btn_lvl_o[0] rises only at the 5th tick edge; exactly one btn_press_o[0] pulse.
- Sub-tick glitch: btn_raw_i[1]=1 for 2 cycles placed between ticks -> no level change, no pulse, btn_evt_o[1] stays 0.
- Clear: with btn_evt_o=5'b00101, drive evt_clr_i=5'b00001 for 1 cycle -> btn_evt_o=5'b00100. Then drive evt_clr_i[2] in the same cycle as a new btn_press_o[2] -> btn_evt_o[2] stays 1.
- Release feature (macro defined): btn_raw_i[3] goes 1->0 after being debounced high -> btn_rel_o[3] pulses 1 cycle and btn_rel_evt_o[3]=1. With the macro undefined, the build elaborates without these ports.

Source files
------------

// File: rtl/input_conditioner.sv
// Two-flop synchroniser, tick-sampled 3-deep debouncer and press event flags for board buttons and switches.
// Optional release pulses and release flags are built when INPUT_COND_RELEASE_EVT_EN is defined.
module input_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int NUM_SW          = 24,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_BTN-1:0] btn_raw_i,
    input  logic [NUM_SW-1:0]  sw_raw_i,
    input  logic [NUM_BTN-1:0] evt_clr_i,
    output logic [NUM_BTN-1:0] btn_lvl_o,
    output logic [NUM_SW-1:0]  sw_lvl_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_evt_o,
`ifdef INPUT_COND_RELEASE_EVT_EN
    output logic [NUM_BTN-1:0] btn_rel_o,
    output logic [NUM_BTN-1:0] btn_rel_evt_o,
`endif
    output logic               tick_o
);

    localparam int N = NUM_BTN + NUM_SW;
    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]       raw;
    logic [N-1:0]       s1;
    logic [N-1:0]       s2;
    logic [N-1:0]       h1;
    logic [N-1:0]       h0;
    logic [N-1:0]       lvl;
    logic [N-1:0]       lvl_nxt;
    logic [N-1:0]       stable;
    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic [NUM_BTN-1:0] btn_now;
    logic [NUM_BTN-1:0] btn_nxt;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] evt;

    assign raw = {sw_raw_i, btn_raw_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == TICK_MAX);

    // A bit qualifies only when the last three tick samples agree.
    assign stable = ~(s2 ^ h1) & ~(h1 ^ h0);

    always_comb begin
        lvl_nxt = lvl;
        if (tick) begin
            lvl_nxt = (stable & s2) | (~stable & lvl);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h1  <= '0;
            h0  <= '0;
            lvl <= '0;
        end else begin
            if (tick) begin
                h1 <= s2;
                h0 <= h1;
            end
            lvl <= lvl_nxt;
        end
    end

    assign btn_now = lvl[NUM_BTN-1:0];
    assign btn_nxt = lvl_nxt[NUM_BTN-1:0];
    assign rise    = btn_nxt & ~btn_now;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            press <= '0;
            evt   <= '0;
        end else begin
            press <= rise;
            evt   <= (evt & ~evt_clr_i) | rise;
        end
    end

`ifdef INPUT_COND_RELEASE_EVT_EN
    logic [NUM_BTN-1:0] fall;
    logic [NUM_BTN-1:0] rel;
    logic [NUM_BTN-1:0] rel_evt;

    assign fall = ~btn_nxt & btn_now;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rel     <= '0;
            rel_evt <= '0;
        end else begin
            rel     <= fall;
            rel_evt <= (rel_evt & ~evt_clr_i) | fall;
        end
    end

    assign btn_rel_o     = rel;
    assign btn_rel_evt_o = rel_evt;
`endif

    assign btn_lvl_o   = btn_now;
    assign sw_lvl_o    = lvl[N-1:NUM_BTN];
    assign btn_press_o = press;
    assign btn_evt_o   = evt;
    assign tick_o      = tick;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Release checks are compiled in when INPUT_COND_RELEASE_EVT_EN is defined.
module tb_input_conditioner;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [4:0]  btn_raw_i;
    logic [23:0] sw_raw_i;
    logic [4:0]  evt_clr_i;
    logic [4:0]  btn_lvl_o;
    logic [23:0] sw_lvl_o;
    logic [4:0]  btn_press_o;
    logic [4:0]  btn_evt_o;
    logic        tick_o;
`ifdef INPUT_COND_RELEASE_EVT_EN
    logic [4:0]  btn_rel_o;
    logic [4:0]  btn_rel_evt_o;
`endif

    int checks = 0;
    int errors = 0;
    int e      = 0;
    int rise;
    int pcnt;
    logic [4:0] pval;

    input_conditioner #(
        .NUM_BTN(5),
        .NUM_SW(24),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .btn_raw_i(btn_raw_i),
        .sw_raw_i(sw_raw_i),
        .evt_clr_i(evt_clr_i),
        .btn_lvl_o(btn_lvl_o),
        .sw_lvl_o(sw_lvl_o),
        .btn_press_o(btn_press_o),
        .btn_evt_o(btn_evt_o),
`ifdef INPUT_COND_RELEASE_EVT_EN
        .btn_rel_o(btn_rel_o),
        .btn_rel_evt_o(btn_rel_evt_o),
`endif
        .tick_o(tick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)",
                   tag, obs, exp, e);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        e++;
    endtask

    task automatic goto(input int n);
        while (e < n) step();
    endtask

    initial begin
        rst_n_i   = 1'b0;
        btn_raw_i = 5'h1F;
        sw_raw_i  = 24'hFFFFFF;
        evt_clr_i = 5'h00;
        step();
        step();
        step();
        check("rst_btn_lvl", 32'(btn_lvl_o), 32'h0);
        check("rst_sw_lvl", 32'(sw_lvl_o), 32'h0);
        check("rst_press", 32'(btn_press_o), 32'h0);
        check("rst_evt", 32'(btn_evt_o), 32'h0);
        check("rst_tick", 32'(tick_o), 32'h0);

        // Release: levels should rise at the third tick edge (edge 12).
        rst_n_i = 1'b1;
        e = 0;
        rise = -1;
        pcnt = 0;
        pval = '0;
        for (int i = 0; i < 14; i++) begin
            step();
            check("tick_phase", 32'(tick_o), 32'((e % 4) == 3));
            if (btn_lvl_o == 5'h1F && rise < 0) rise = e;
            if (btn_press_o != 5'h00) begin
                pcnt++;
                pval = btn_press_o;
            end
        end
        check("boot_rise_edge", 32'(rise), 32'd12);
        check("boot_press_cnt", 32'(pcnt), 32'd1);
        check("boot_press_val", 32'(pval), 32'h1F);
        check("boot_btn_lvl", 32'(btn_lvl_o), 32'h1F);
        check("boot_sw_lvl", 32'(sw_lvl_o), 32'hFFFFFF);
        check("boot_evt", 32'(btn_evt_o), 32'h1F);

        // Drop all buttons; falls at edge 28, flags stay sticky.
        btn_raw_i = 5'h00;
        goto(30);
        check("fall_lvl", 32'(btn_lvl_o), 32'h0);
        check("fall_press", 32'(btn_press_o), 32'h0);
        check("fall_evt", 32'(btn_evt_o), 32'h1F);
        check("fall_sw", 32'(sw_lvl_o), 32'hFFFFFF);
        evt_clr_i = 5'h1F;
        step();
        evt_clr_i = 5'h00;
        check("clr_all", 32'(btn_evt_o), 32'h0);

        // Clean press on button 2 at edge 31 -> level at edge 44.
        btn_raw_i[2] = 1'b1;
        rise = -1;
        for (int i = 0; i < 20 && rise < 0; i++) begin
            step();
            if (btn_lvl_o[2]) rise = e;
        end
        check("press2_edge", 32'(rise), 32'd44);
        check("press2_pulse", 32'(btn_press_o), 32'h04);
        step();
        check("press2_drop", 32'(btn_press_o), 32'h0);
        check("press2_evt", 32'(btn_evt_o), 32'h04);
        btn_raw_i[2] = 1'b0;
        goto(58);
        check("rel2_lvl", 32'(btn_lvl_o), 32'h0);
        check("rel2_evt", 32'(btn_evt_o), 32'h04);

        // Bounce on button 0: ticks 64..80 see 1,0,1,1,1.
        btn_raw_i[0] = 1'b1;
        goto(64);
        btn_raw_i[0] = 1'b0;
        goto(66);
        btn_raw_i[0] = 1'b1;
        rise = -1;
        pcnt = 0;
        while (e < 84) begin
            step();
            if (btn_lvl_o[0] && rise < 0) rise = e;
            if (btn_press_o[0]) pcnt++;
        end
        check("bounce_edge", 32'(rise), 32'd80);
        check("bounce_pulses", 32'(pcnt), 32'd1);
        check("bounce_evt", 32'(btn_evt_o), 32'h05);

        evt_clr_i = 5'b00001;
        step();
        evt_clr_i = 5'h00;
        check("clr_bit0", 32'(btn_evt_o), 32'h04);

        // Two-cycle glitch on button 1 between ticks 88 and 92.
        goto(86);
        btn_raw_i[1] = 1'b1;
        step();
        step();
        btn_raw_i[1] = 1'b0;
        pcnt = 0;
        while (e < 100) begin
            step();
            if (btn_press_o[1] || btn_lvl_o[1]) pcnt++;
        end
        check("glitch_seen", 32'(pcnt), 32'd0);
        check("glitch_lvl", 32'(btn_lvl_o), 32'h01);
        check("glitch_evt", 32'(btn_evt_o), 32'h04);

        // Clear of bit 2 lands on the same edge as its new press.
        btn_raw_i[2] = 1'b1;
        goto(111);
        evt_clr_i = 5'b00100;
        step();
        evt_clr_i = 5'h00;
        check("setwin_press", 32'(btn_press_o), 32'h04);
        check("setwin_evt", 32'(btn_evt_o), 32'h04);
        step();
        check("setwin_hold", 32'(btn_evt_o), 32'h04);
        check("setwin_drop", 32'(btn_press_o), 32'h0);
        evt_clr_i = 5'b00010;
        step();
        evt_clr_i = 5'h00;
        check("clr_empty", 32'(btn_evt_o), 32'h04);

        // Button 3 up at edge 128, down at edge 144.
        btn_raw_i[3] = 1'b1;
        goto(128);
        check("b3_up_lvl", 32'(btn_lvl_o[3]), 32'd1);
        check("b3_up_press", 32'(btn_press_o), 32'h08);
        goto(130);
        btn_raw_i[3] = 1'b0;
        goto(143);
        check("b3_hold_lvl", 32'(btn_lvl_o[3]), 32'd1);
        check("tick_143", 32'(tick_o), 32'd1);
        step();
        check("b3_dn_lvl", 32'(btn_lvl_o[3]), 32'd0);
        check("b3_dn_press", 32'(btn_press_o), 32'h0);
        check("b3_evt", 32'(btn_evt_o), 32'h0C);
`ifdef INPUT_COND_RELEASE_EVT_EN
        check("rel3_pulse", 32'(btn_rel_o), 32'h08);
        check("rel3_evt", 32'(btn_rel_evt_o[3]), 32'd1);
        step();
        check("rel3_drop", 32'(btn_rel_o), 32'h0);
        check("rel3_sticky", 32'(btn_rel_evt_o[3]), 32'd1);
        evt_clr_i = 5'b01000;
        step();
        evt_clr_i = 5'h00;
        check("rel3_clr", 32'(btn_rel_evt_o[3]), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
